// File: rtl/utype_pkg.sv
// utype shared definitions.
// Width default and U-type select codes.
package utype_pkg;

  localparam int XLEN_DEF = 32;
  localparam int SEL_W    = 6;

  localparam logic [SEL_W-1:0] SEL_LUI   = 6'b000001;
  localparam logic [SEL_W-1:0] SEL_AUIPC = 6'b000010;

endpackage

// File: rtl/utype_alu.sv
// utype_alu: combinational LUI/AUIPC result and op_ok decode.
// in: pc, imm_u, aluSelect; out: w_result, w_ok.
module utype_alu
  import utype_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm_u,
  input  logic [SEL_W-1:0] aluSelect,
  output logic [XLEN-1:0]  w_result,
  output logic             w_ok
);

  always_comb begin
    w_result = '0;
    w_ok     = 1'b0;
    unique case (1'b1)
      (aluSelect == SEL_LUI): begin
        w_result = imm_u;
        w_ok     = 1'b1;
      end
      (aluSelect == SEL_AUIPC): begin
        w_result = pc + imm_u;
        w_ok     = 1'b1;
      end
      default: begin
        w_result = '0;
        w_ok     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/utype.sv
// utype: one-cycle registered U-type unit (LUI/AUIPC).
// in: clk, rst_n, pc, imm_u, aluSelect, in_valid, stall, flush; out: result, out_valid, op_ok.
module utype
  import utype_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm_u,
  input  logic [SEL_W-1:0] aluSelect,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [XLEN-1:0]  result,
  output logic             out_valid,
  output logic             op_ok
);

  logic [XLEN-1:0] w_result;
  logic            w_ok;
  logic [XLEN-1:0] r_result;
  logic            r_valid;
  logic            r_ok;

  utype_alu #(.XLEN(XLEN)) u_alu (
    .pc        (pc),
    .imm_u     (imm_u),
    .aluSelect (aluSelect),
    .w_result  (w_result),
    .w_ok      (w_ok)
  );

  // flush beats stall beats capture; idle cycles load zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_valid  <= 1'b0;
      r_ok     <= 1'b0;
    end else if (flush) begin
      r_result <= '0;
      r_valid  <= 1'b0;
      r_ok     <= 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        r_result <= w_result;
        r_valid  <= 1'b1;
        r_ok     <= w_ok;
      end else begin
        r_result <= '0;
        r_valid  <= 1'b0;
        r_ok     <= 1'b0;
      end
    end
  end

  assign result    = r_result;
  assign out_valid = r_valid;
  assign op_ok     = r_ok;

endmodule

// File: tb/tb_utype.sv
// tb_utype: directed vectors for utype.
// Checks reset, LUI/AUIPC/unknown, wrap, stall/flush, async reset.
module tb_utype;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] imm_u;
  logic [5:0]  aluSelect;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [31:0] result;
  logic        out_valid;
  logic        op_ok;

  int vectors;
  int miscompares;

  utype #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .imm_u     (imm_u),
    .aluSelect (aluSelect),
    .in_valid  (in_valid),
    .stall     (stall),
    .flush     (flush),
    .result    (result),
    .out_valid (out_valid),
    .op_ok     (op_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [31:0] r,
                      input logic v, input logic k);
    chk({tag, ".result"}, result, r);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".op_ok"}, {31'd0, op_ok}, {31'd0, k});
  endtask

  task automatic step(input logic [5:0] s, input logic [31:0] p,
                      input logic [31:0] im, input logic iv,
                      input logic st, input logic fl);
    @(negedge clk);
    aluSelect = s;
    pc        = p;
    imm_u     = im;
    in_valid  = iv;
    stall     = st;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    pc        = '0;
    imm_u     = '0;
    aluSelect = '0;
    in_valid  = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;

    #12;
    outs("reset", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step(6'b000010, 32'h0000_1000, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
    outs("auipc", 32'h0000_1010, 1'b1, 1'b1);

    step(6'b000001, 32'h0000_1000, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
    outs("lui", 32'h0000_0010, 1'b1, 1'b1);

    step(6'b111111, 32'h0000_1000, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
    outs("unknown", 32'h0, 1'b1, 1'b0);

    step(6'b000010, 32'hFFFF_F000, 32'h0000_2000, 1'b1, 1'b0, 1'b0);
    outs("wrap", 32'h0000_1000, 1'b1, 1'b1);

    step(6'b000001, 32'h0, 32'hABCD_E123, 1'b1, 1'b0, 1'b0);
    outs("lui_lowbits", 32'hABCD_E123, 1'b1, 1'b1);

    step(6'b000001, 32'h0, 32'h1234_5000, 1'b0, 1'b0, 1'b0);
    chk("idle.result", result, 32'h0);
    chk("idle.out_valid", {31'd0, out_valid}, 32'd0);

    step(6'b000010, 32'h0000_1000, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
    outs("cap", 32'h0000_1010, 1'b1, 1'b1);
    step(6'b000001, 32'h1111_1000, 32'h5555_5000, 1'b1, 1'b1, 1'b0);
    outs("stall1", 32'h0000_1010, 1'b1, 1'b1);
    step(6'b111111, 32'h2222_2000, 32'h6666_6000, 1'b1, 1'b1, 1'b0);
    outs("stall2", 32'h0000_1010, 1'b1, 1'b1);
    step(6'b000010, 32'h3333_3000, 32'h7777_7000, 1'b0, 1'b1, 1'b0);
    outs("stall3", 32'h0000_1010, 1'b1, 1'b1);
    step(6'b000010, 32'h3333_3000, 32'h7777_7000, 1'b1, 1'b1, 1'b1);
    outs("flush", 32'h0, 1'b0, 1'b0);

    step(6'b000010, 32'h0000_2000, 32'h0000_3000, 1'b1, 1'b0, 1'b0);
    outs("pre_rst", 32'h0000_5000, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    outs("async_rst", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(6'b000001, 32'h0, 32'h0000_7000, 1'b1, 1'b0, 1'b0);
    outs("post_rst", 32'h0000_7000, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
